// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types, default widths and saturating arithmetic for the SNN classifier layer
//
// Purpose : FSM state enum, default parameter values and a saturating add helper
//           used by snn_classifier_layer and snn_lif_neuron.
// Ports   : none (package).

package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DECIDE = 2'd3
    } state_e;

    localparam int DEF_NUM_IN     = 11;
    localparam int DEF_NUM_OUT    = 9;
    localparam int DEF_W_W        = 20;
    localparam int DEF_I_W        = 23;
    localparam int DEF_V_W        = 24;
    localparam int DEF_WINDOW     = 16;
    localparam int DEF_LEAK_SHIFT = 4;
    localparam int DEF_VTH        = 100000;

    // Adds two sign-extended operands and clamps the result to the signed
    // range of a w-bit value. Callers truncate the result back to w bits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// rtl/snn_lif_neuron.sv - one leaky integrate-and-fire class neuron
//
// Purpose : holds a membrane potential; on update_i applies leak plus the
//           synaptic current, fires and resets when the threshold is reached.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           update_i        one-cycle strobe: apply the membrane update this cycle
//           cur_i [I_W]     signed synaptic current for this update
//           fire_now_o      combinational: neuron fires on this update
//           spk_o           registered one-cycle spike pulse

module snn_lif_neuron
    import snn_pkg::*;
#(
    parameter int I_W        = DEF_I_W,
    parameter int V_W        = DEF_V_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int VTH        = DEF_VTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  update_i,
    input  logic signed [I_W-1:0] cur_i,
    output logic                  fire_now_o,
    output logic                  spk_o
);

    localparam logic signed [63:0] VTH_S = 64'(VTH);

    logic signed [V_W-1:0] v_q, v_d;
    logic                  spk_q, spk_d;
    logic signed [63:0]    v_next;

    always_comb begin
        // Leaked value always fits in V_W, so only the current add can overflow.
        v_next = sat_add(64'(v_q) - 64'(v_q >>> LEAK_SHIFT), 64'(cur_i), V_W);
        v_d    = v_q;
        spk_d  = 1'b0;
        if (update_i) begin
            if (v_next >= VTH_S) begin
                spk_d = 1'b1;
                v_d   = '0;
            end else begin
                v_d = V_W'(v_next);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            spk_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            spk_q <= spk_d;
        end
    end

    assign fire_now_o = spk_d;
    assign spk_o      = spk_q;

endmodule

// File: rtl/snn_classifier_layer.sv
// rtl/snn_classifier_layer.sv - spiking classifier layer with per-window spike-count decision
//
// Purpose : accepts binary feature-spike samples, accumulates weighted synaptic
//           currents serially over the inputs, updates NUM_OUT LIF neurons and,
//           every WINDOW samples, reports the most active neuron.
// Config  : define SNN_WTA_EN to enable the winner-take-all decision outputs;
//           without it cls_valid/cls_idx/cls_cnt are constant zero.
// Ports   : clk, rst                       clock, asynchronous active-high reset
//           in_valid, in_ready, in_spk     feature-sample handshake and spike vector
//           wr_en, wr_out, wr_in, wr_data  weight write port (honoured only when idle)
//           out_spk                        per-neuron one-cycle spike pulse
//           cls_valid, cls_idx, cls_cnt    window decision pulse, winner index and count

module snn_classifier_layer
    import snn_pkg::*;
#(
    parameter int NUM_IN     = DEF_NUM_IN,
    parameter int NUM_OUT    = DEF_NUM_OUT,
    parameter int W_W        = DEF_W_W,
    parameter int I_W        = DEF_I_W,
    parameter int V_W        = DEF_V_W,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int VTH        = DEF_VTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [NUM_IN-1:0]                             in_spk,
    input  logic                                          wr_en,
    input  logic [(NUM_OUT > 1 ? $clog2(NUM_OUT) : 1)-1:0] wr_out,
    input  logic [(NUM_IN > 1 ? $clog2(NUM_IN) : 1)-1:0]   wr_in,
    input  logic [W_W-1:0]                                wr_data,
    output logic [NUM_OUT-1:0]                            out_spk,
    output logic                                          cls_valid,
    output logic [(NUM_OUT > 1 ? $clog2(NUM_OUT) : 1)-1:0] cls_idx,
    output logic [$clog2(WINDOW + 1)-1:0]                 cls_cnt
);

    localparam int OUT_IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int IN_IW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    localparam logic [IN_IW-1:0] IDX_LAST = IN_IW'(NUM_IN - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WINDOW);

    state_e state_q, state_d;

    logic                  do_start, do_accum, do_update, do_decide;

    logic [NUM_IN-1:0]     spk_q, spk_d;
    logic [IN_IW-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      win_q, win_d;
    logic signed [W_W-1:0] w_q   [NUM_OUT][NUM_IN];
    logic signed [I_W-1:0] acc_q [NUM_OUT];
    logic signed [I_W-1:0] acc_d [NUM_OUT];
    logic [CNT_W-1:0]      cnt_q [NUM_OUT];
    logic [CNT_W-1:0]      cnt_d [NUM_OUT];

    logic [NUM_OUT-1:0]    fire_now;
    logic [NUM_OUT-1:0]    spk_out;

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        do_start  = 1'b0;
        do_accum  = 1'b0;
        do_update = 1'b0;
        do_decide = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    do_start = 1'b1;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                do_accum = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                do_update = 1'b1;
                state_d   = (win_q == WIN_LAST) ? ST_DECIDE : ST_IDLE;
            end
            ST_DECIDE: begin
                do_decide = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);

    // ---------------- datapath next state ----------------
    always_comb begin
        spk_d = spk_q;
        idx_d = idx_q;
        win_d = win_q;
        acc_d = acc_q;
        cnt_d = cnt_q;

        if (do_start) begin
            spk_d = in_spk;
            idx_d = '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                acc_d[j] = '0;
            end
        end

        // One input column per cycle: every neuron adds its weight for input idx_q.
        if (do_accum) begin
            idx_d = idx_q + 1'b1;
            if (spk_q[idx_q]) begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    acc_d[j] = I_W'(sat_add(64'(acc_q[j]), 64'(w_q[j][idx_q]), I_W));
                end
            end
        end

        if (do_update) begin
            win_d = win_q + 1'b1;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (fire_now[j] && (cnt_q[j] != CNT_MAX)) begin
                    cnt_d[j] = cnt_q[j] + 1'b1;
                end
            end
        end

        if (do_decide) begin
            win_d = '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                cnt_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spk_q <= '0;
            idx_q <= '0;
            win_q <= '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                acc_q[j] <= '0;
                cnt_q[j] <= '0;
                for (int k = 0; k < NUM_IN; k++) begin
                    w_q[j][k] <= '0;
                end
            end
        end else begin
            spk_q <= spk_d;
            idx_q <= idx_d;
            win_q <= win_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            // Writes outside IDLE are discarded so a sample never sees a weight change mid-flight.
            if (wr_en && (state_q == ST_IDLE) &&
                (int'(wr_out) < NUM_OUT) && (int'(wr_in) < NUM_IN)) begin
                w_q[wr_out][wr_in] <= wr_data;
            end
        end
    end

    // ---------------- neurons ----------------
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_neuron
        snn_lif_neuron #(
            .I_W        (I_W),
            .V_W        (V_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .VTH        (VTH)
        ) u_neuron (
            .clk        (clk),
            .rst        (rst),
            .update_i   (do_update),
            .cur_i      (acc_q[j]),
            .fire_now_o (fire_now[j]),
            .spk_o      (spk_out[j])
        );
    end

    assign out_spk = spk_out;

    // ---------------- window decision ----------------
`ifdef SNN_WTA_EN
    logic [OUT_IW-1:0] best_idx;
    logic [CNT_W-1:0]  best_cnt;
    logic              cls_valid_q;
    logic [OUT_IW-1:0] cls_idx_q;
    logic [CNT_W-1:0]  cls_cnt_q;

    // Strict '>' keeps the lowest index on ties; all-zero counts leave index 0, count 0.
    always_comb begin
        best_idx = '0;
        best_cnt = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (cnt_q[j] > best_cnt) begin
                best_idx = OUT_IW'(j);
                best_cnt = cnt_q[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_valid_q <= 1'b0;
            cls_idx_q   <= '0;
            cls_cnt_q   <= '0;
        end else begin
            cls_valid_q <= do_decide;
            cls_idx_q   <= do_decide ? best_idx : '0;
            cls_cnt_q   <= do_decide ? best_cnt : '0;
        end
    end

    assign cls_valid = cls_valid_q;
    assign cls_idx   = cls_idx_q;
    assign cls_cnt   = cls_cnt_q;
`else
    assign cls_valid = 1'b0;
    assign cls_idx   = '0;
    assign cls_cnt   = '0;
`endif

endmodule

// File: tb/tb_snn_classifier_layer.sv
// tb/tb_snn_classifier_layer.sv - self-checking bench for snn_classifier_layer against a behavioural model

module tb_snn_classifier_layer;

    localparam int NUM_IN     = 11;
    localparam int NUM_OUT    = 9;
    localparam int W_W        = 20;
    localparam int I_W        = 23;
    localparam int V_W        = 24;
    localparam int WINDOW     = 4;
    localparam int LEAK_SHIFT = 4;
    localparam int VTH        = 100000;
    localparam int OUT_IW     = 4;
    localparam int IN_IW      = 4;
    localparam int CNT_W      = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [NUM_IN-1:0]   in_spk;
    logic                wr_en;
    logic [OUT_IW-1:0]   wr_out;
    logic [IN_IW-1:0]    wr_in;
    logic [W_W-1:0]      wr_data;
    logic [NUM_OUT-1:0]  out_spk;
    logic                cls_valid;
    logic [OUT_IW-1:0]   cls_idx;
    logic [CNT_W-1:0]    cls_cnt;

    snn_classifier_layer #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .W_W(W_W), .I_W(I_W), .V_W(V_W),
        .WINDOW(WINDOW), .LEAK_SHIFT(LEAK_SHIFT), .VTH(VTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_spk(in_spk),
        .wr_en(wr_en), .wr_out(wr_out), .wr_in(wr_in), .wr_data(wr_data),
        .out_spk(out_spk), .cls_valid(cls_valid), .cls_idx(cls_idx), .cls_cnt(cls_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    longint m_w   [NUM_OUT][NUM_IN];
    longint m_v   [NUM_OUT];
    int     m_cnt [NUM_OUT];
    int     m_win;

    logic [NUM_OUT-1:0] e_spk;
    bit                 e_dec;
    int                 e_idx;
    int                 e_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NUM_OUT; j++) begin
            m_v[j]   = 0;
            m_cnt[j] = 0;
            for (int k = 0; k < NUM_IN; k++) m_w[j][k] = 0;
        end
        m_win = 0;
    endtask

    task automatic model_sample(input logic [NUM_IN-1:0] bits);
        longint acc;
        longint vn;
        e_spk = '0;
        e_dec = 1'b0;
        e_idx = 0;
        e_cnt = 0;
        for (int j = 0; j < NUM_OUT; j++) begin
            acc = 0;
            for (int k = 0; k < NUM_IN; k++) begin
                if (bits[k]) acc = clamp(acc + m_w[j][k], I_W);
            end
            vn = clamp(m_v[j] - (m_v[j] >>> LEAK_SHIFT) + acc, V_W);
            if (vn >= VTH) begin
                e_spk[j] = 1'b1;
                m_v[j]   = 0;
                if (m_cnt[j] < WINDOW) m_cnt[j]++;
            end else begin
                m_v[j] = vn;
            end
        end
        m_win++;
        if (m_win == WINDOW) begin
            e_dec = 1'b1;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (m_cnt[j] > e_cnt) begin
                    e_cnt = m_cnt[j];
                    e_idx = j;
                end
            end
            for (int j = 0; j < NUM_OUT; j++) m_cnt[j] = 0;
            m_win = 0;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_spk   = '0;
        wr_en    = 1'b0;
        wr_out   = '0;
        wr_in    = '0;
        wr_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_w(input int o, input int i, input longint d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_out  = OUT_IW'(o);
        wr_in   = IN_IW'(i);
        wr_data = W_W'(d);
        @(posedge clk);
        #1 wr_en = 1'b0;
        m_w[o][i] = d;
    endtask

    // Sends one sample and checks the full response timeline; optionally tries
    // a weight write while the layer is accumulating (it must be ignored).
    task automatic send(input logic [NUM_IN-1:0] bits, input bit wr_during);
        bit exp_cls;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_spk   = bits;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_sample(bits);
        if (wr_during) begin
            wr_en   = 1'b1;
            wr_out  = OUT_IW'(1);
            wr_in   = '0;
            wr_data = W_W'(200000);
        end
        @(posedge clk);
        #1 wr_en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("in_ready_busy", 64'(in_ready), 64'(0));
        check("out_spk_early", 64'(out_spk), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("out_spk", 64'(out_spk), 64'(e_spk));
        check("cls_quiet", 64'(cls_valid), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("out_spk_pulse", 64'(out_spk), 64'(0));
`ifdef SNN_WTA_EN
        exp_cls = e_dec;
`else
        exp_cls = 1'b0;
`endif
        check("cls_valid", 64'(cls_valid), 64'(exp_cls));
        if (exp_cls) begin
            check("cls_idx", 64'(cls_idx), 64'(e_idx));
            check("cls_cnt", 64'(cls_cnt), 64'(e_cnt));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_OUT-1:0] spk_seen;
        logic               cls_seen;

        do_reset();
        @(negedge clk);
        check("rst_out_spk", 64'(out_spk), 64'(0));
        check("rst_cls_valid", 64'(cls_valid), 64'(0));
        check("rst_cls_idx", 64'(cls_idx), 64'(0));
        check("rst_cls_cnt", 64'(cls_cnt), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Single strong weight: neuron 2 fires 12 cycles after transfer.
        write_w(2, 0, 120000);
        send(11'b1, 1'b0);

        // Sub-threshold then leak plus second input crosses threshold.
        do_reset();
        write_w(0, 0, 60000);
        send(11'b1, 1'b0);
        send(11'b1, 1'b0);

        // Window decision with a tie between neurons 3 and 5.
        do_reset();
        write_w(3, 0, 100000);
        write_w(5, 1, 100000);
        send(11'b11, 1'b0);
        send(11'b100, 1'b0);
        send(11'b11, 1'b0);
        send(11'b100, 1'b0);

        // Maximum positive weights everywhere: accumulator saturates, no wrap.
        do_reset();
        for (int j = 0; j < NUM_OUT; j++)
            for (int k = 0; k < NUM_IN; k++)
                write_w(j, k, 524287);
        send('1, 1'b0);
        send('1, 1'b0);

        // Weight write during ACCUM is dropped.
        do_reset();
        send(11'b1, 1'b1);
        send(11'b1, 1'b0);

        // Reset during ACCUM aborts the sample.
        write_w(4, 0, 150000);
        @(negedge clk);
        in_valid = 1'b1;
        in_spk   = 11'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_spk", 64'(out_spk), 64'(0));
        check("midrst_cls_valid", 64'(cls_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        spk_seen = '0;
        cls_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            spk_seen = spk_seen | out_spk;
            cls_seen = cls_seen | cls_valid;
        end
        check("midrst_no_spk", 64'(spk_seen), 64'(0));
        check("midrst_no_cls", 64'(cls_seen), 64'(0));
        check("midrst_ready", 64'(in_ready), 64'(1));
        send(11'b1, 1'b0);

        // Randomised weights and samples, with occasional mid-run rewrites.
        do_reset();
        for (int n = 0; n < 40; n++)
            write_w($urandom_range(NUM_OUT - 1), $urandom_range(NUM_IN - 1),
                    longint'($urandom_range(140000)) - 50000);
        for (int s = 0; s < 24; s++) begin
            send(NUM_IN'($urandom), 1'b0);
            if ((s % 4) == 3) begin
                for (int n = 0; n < 3; n++)
                    write_w($urandom_range(NUM_OUT - 1), $urandom_range(NUM_IN - 1),
                            longint'($urandom_range(300000)) - 150000);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
